bextdep_dispatch: RTL
=====================

# bextdep_dispatch

Request-queue and sequencing front end for the multi-cycle `simplebextdep` bit-extract/deposit unit. It accepts tagged bext/bdep requests over a valid/ready interface and buffers them in a FIFO. It issues them one at a time to the unit through its start/busy/done handshake, then returns each result with its tag over a valid/ready output. Sits between the issuing pipeline and `simplebextdep`; `simplebextdep` is instantiated outside this block and wired to the `unit_*` ports.

## Interface
Parameters:
- DEPTH, 4, request FIFO entries; power of two, ≥2
- TAGW, 4, request tag width

Ports:
- clock  in  1  clock; all state updates on posedge
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  FIFO can accept; = !full
- in_bdep  in  1  0 = bext, 1 = bdep
- in_rs1, in_rs2  in  32 each  operands
- in_tag  in  TAGW  request tag
- unit_start  out  1  one-cycle start pulse to unit
- unit_bdep  out  1  op of in-flight job
- unit_rs1, unit_rs2  out  32 each  operands of in-flight job
- unit_busy  in  1  unit busy
- unit_done  in  1  unit result valid (1 cycle)
- unit_rd  in  32  unit result
- out_valid  out  1  result held
- out_ready  in  1  consumer accepts
- out_rd  out  32  result
- out_tag  out  TAGW  tag of result
- err  out  1  sticky protocol error
- stat_jobs  out  32  completed output handshakes, wraps
- stat_cycles  out  32  cycles with FSM not IDLE, wraps

## Operation
- FIFO: push on in_valid && in_ready; pop at issue. No bypass: when full, in_ready = 0 even if a pop occurs the same cycle. Entry = {bdep, rs1, rs2, tag}. Pointers wrap mod DEPTH; count is 0..DEPTH.
- FSM states:
  - IDLE: issue when FIFO non-empty and the output slot is free. Free = !out_valid, or out_valid && out_ready this cycle. On issue: pop the head into unit_bdep/rs1/rs2 and the in-flight tag register, register unit_start = 1, go ISSUE.
  - ISSUE: unit_start = 0; go WAIT.
  - WAIT: on unit_done, capture unit_rd → out_rd and in-flight tag → out_tag, set out_valid, go IDLE.
- unit_rs1/rs2/bdep stay stable from issue until the next issue.
- Output slot: out_valid clears on out_valid && out_ready unless a capture occurs the same cycle. Capture cannot overlap a held result, because issue requires a free slot. out_rd/out_tag stay stable while out_valid && !out_ready.
- Ordering: results leave in request order; one job in flight max.
- err sets, and stays set until reset, on unit_done outside WAIT or on unit_done && unit_start. unit_done outside WAIT is otherwise ignored (no capture).
- stat_jobs increments on every output handshake. stat_cycles increments each cycle the state is ISSUE or WAIT.

## Timing
- Reset values: in_ready = 1, unit_start = 0, unit_bdep = 0, unit_rs1 = unit_rs2 = 0, out_valid = 0, out_rd = 0, out_tag = 0, err = 0, stat_* = 0, FIFO empty, state IDLE.
- Reset mid-operation discards the FIFO, the in-flight job and any held result. The same reset must drive `simplebextdep`.
- Push at edge N into an empty FIFO with the slot free:
  - unit_start is high during cycle N+1→N+2.
  - If unit_done is sampled at edge D, out_valid is high from edge D.
- Back-to-back issue: IDLE at D → unit_start at D+1 when the FIFO is non-empty and the slot is free or being consumed.
- Dispatcher overhead per job = 2 cycles beyond unit latency (ISSUE + IDLE).

## Test plan
- Single bext: rs1=0x12345678, rs2=0x0000FF00, tag=3 → exactly one unit_start pulse; then out_valid with out_rd=0x00000056, out_tag=3; stat_jobs=1.
- Single bdep: rs1=0x000000FF, rs2=0xF0F0F0F0, tag=5 → out_rd=0x0000F0F0, out_tag=5.
- Burst: push DEPTH+2 requests with tags 0..5 while out_ready=1 → in_ready drops after 4 accepted with no in-flight pop; all 6 accepted eventually; outputs in tag order 0..5, each rd correct.
- Backpressure: out_ready=0, two requests queued → after the first result, out_valid holds stable and no second unit_start occurs. Raise out_ready → the second unit_start fires the next cycle.
- Reset in WAIT with 2 requests queued → after reset: out_valid=0, in_ready=1, FIFO empty, no later out_valid without new requests.
- Spurious unit_done in IDLE → err=1 and stays 1; out_valid unchanged; err clears only on reset.

Source files
------------

// File: rtl/bextdep_dispatch.sv
// Request FIFO and one-job-at-a-time sequencer in front of the simplebextdep
// bit-extract/deposit unit; results return with their tags in request order.
module bextdep_dispatch #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAGW  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_bdep,
  input  logic [31:0]     in_rs1,
  input  logic [31:0]     in_rs2,
  input  logic [TAGW-1:0] in_tag,
  output logic            unit_start,
  output logic            unit_bdep,
  output logic [31:0]     unit_rs1,
  output logic [31:0]     unit_rs2,
  input  logic            unit_busy,
  input  logic            unit_done,
  input  logic [31:0]     unit_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_rd,
  output logic [TAGW-1:0] out_tag,
  output logic            err,
  output logic [31:0]     stat_jobs,
  output logic [31:0]     stat_cycles
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef struct packed {
    logic            bdep;
    logic [31:0]     rs1;
    logic [31:0]     rs2;
    logic [TAGW-1:0] tag;
  } entry_t;

  state_t          state;
  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [TAGW-1:0] flight_tag;
  logic            full;
  logic            empty;
  logic            push;
  logic            slot_free;
  logic            issue;
  logic            capture;
  logic            handshake;
  logic            unused_busy;

  // The unit's busy flag is redundant with our own WAIT tracking.
  assign unused_busy = unit_busy;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign handshake = out_valid && out_ready;
  assign slot_free = !out_valid || out_ready;
  assign issue     = (state == IDLE) && !empty && slot_free;
  assign capture   = (state == WAIT) && unit_done;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= '{bdep: in_bdep, rs1: in_rs1, rs2: in_rs2, tag: in_tag};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      flight_tag  <= '0;
      unit_start  <= 1'b0;
      unit_bdep   <= 1'b0;
      unit_rs1    <= '0;
      unit_rs2    <= '0;
      out_valid   <= 1'b0;
      out_rd      <= '0;
      out_tag     <= '0;
      err         <= 1'b0;
      stat_jobs   <= '0;
      stat_cycles <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      unit_start <= issue;
      if (issue) begin
        unit_bdep  <= head.bdep;
        unit_rs1   <= head.rs1;
        unit_rs2   <= head.rs2;
        flight_tag <= head.tag;
      end

      case (state)
        IDLE:    if (issue) state <= ISSUE;
        ISSUE:   state <= WAIT;
        WAIT:    if (unit_done) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Issue waits for a free slot, so capture never overwrites a held result.
      if (capture) begin
        out_valid <= 1'b1;
        out_rd    <= unit_rd;
        out_tag   <= flight_tag;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end

      if (unit_done && ((state != WAIT) || unit_start)) begin
        err <= 1'b1;
      end

      if (handshake) begin
        stat_jobs <= stat_jobs + 32'd1;
      end
      if (state != IDLE) begin
        stat_cycles <= stat_cycles + 32'd1;
      end
    end
  end

endmodule
